uart_frame_decoder: RTL and testbench

Byte-stream frame decoder between the UART receiver and the AXI command engine of the uart2axi bridge. It consumes raw received bytes, strips the START/STOP framing and ESCAPE stuffing, and emits the payload as an 8-bit AXI-Stream. TLAST marks the last payload byte of each frame. Framing violations are reported as single-cycle pulses.

---
 rtl/uart_frame_decoder.sv | 137 +++++++++++++
 tb/tb_uart_frame_decoder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_decoder.sv
// Byte-stream frame decoder: strips START/STOP framing and ESCAPE stuffing from
// received UART bytes and emits the payload as an 8-bit AXI-Stream with TLAST.
module uart_frame_decoder #(
  parameter logic [7:0] START_BYTE    = 8'd125,
  parameter logic [7:0] STOP_BYTE     = 8'd126,
  parameter logic [7:0] ESCAPE_BYTE   = 8'd127,
  parameter int         MAX_FRAME_LEN = 1024
) (
  input  logic       aclk,
  input  logic       areset,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic [7:0] s_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tlast,
  output logic       in_frame,
  output logic       err_restart,
  output logic       err_overflow,
  output logic       frame_empty
);
  localparam int CW = $clog2(MAX_FRAME_LEN + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_FRAME_LEN);

  typedef enum logic [1:0] {IDLE, FRAME, ESC} state_t;

  state_t          state, state_n;
  logic            h_valid, h_valid_n;
  logic [7:0]      h_data, h_data_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            push, push_last, is_data;
  logic            restart_n, overflow_n, empty_n;
  logic            acc;

  // One raw byte yields at most one output byte, so a free-or-draining
  // output register is the only backpressure condition.
  assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
  assign acc           = s_axis_tvalid && s_axis_tready;

  always_comb begin
    state_n    = state;
    h_valid_n  = h_valid;
    h_data_n   = h_data;
    cnt_n      = cnt;
    push       = 1'b0;
    push_last  = 1'b0;
    is_data    = 1'b0;
    restart_n  = 1'b0;
    overflow_n = 1'b0;
    empty_n    = 1'b0;
    if (acc) begin
      case (state)
        IDLE: begin
          if (s_axis_tdata == START_BYTE) begin
            state_n   = FRAME;
            cnt_n     = '0;
            h_valid_n = 1'b0;
          end
        end
        FRAME: begin
          if (s_axis_tdata == ESCAPE_BYTE) begin
            state_n = ESC;
          end else if (s_axis_tdata == STOP_BYTE) begin
            push      = h_valid;
            push_last = 1'b1;
            empty_n   = !h_valid;
            h_valid_n = 1'b0;
            state_n   = IDLE;
          end else if (s_axis_tdata == START_BYTE) begin
            push      = h_valid;
            push_last = 1'b1;
            restart_n = 1'b1;
            cnt_n     = '0;
            h_valid_n = 1'b0;
          end else begin
            is_data = 1'b1;
          end
        end
        ESC: begin
          is_data = 1'b1;
          state_n = FRAME;
        end
        default: state_n = IDLE;
      endcase

      if (is_data) begin
        if (cnt == CNT_MAX) begin
          // Close the frame on the held byte; the excess byte and the rest
          // of the frame are swallowed by IDLE.
          push       = 1'b1;
          push_last  = 1'b1;
          overflow_n = 1'b1;
          h_valid_n  = 1'b0;
          state_n    = IDLE;
        end else begin
          push      = h_valid;
          h_data_n  = s_axis_tdata;
          h_valid_n = 1'b1;
          cnt_n     = cnt + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state         <= IDLE;
      h_valid       <= 1'b0;
      h_data        <= 8'h00;
      cnt           <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= 8'h00;
      m_axis_tlast  <= 1'b0;
      in_frame      <= 1'b0;
      err_restart   <= 1'b0;
      err_overflow  <= 1'b0;
      frame_empty   <= 1'b0;
    end else begin
      state        <= state_n;
      h_valid      <= h_valid_n;
      h_data       <= h_data_n;
      cnt          <= cnt_n;
      in_frame     <= (state_n != IDLE);
      err_restart  <= restart_n;
      err_overflow <= overflow_n;
      frame_empty  <= empty_n;
      if (push) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= h_data;
        m_axis_tlast  <= push_last;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed bench for uart_frame_decoder (MAX_FRAME_LEN=4 so overflow is reachable).
module tb_uart_frame_decoder;
  logic       aclk = 1'b0;
  logic       areset = 1'b1;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tready;
  logic [7:0] s_axis_tdata = 8'h00;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tlast;
  logic       in_frame, err_restart, err_overflow, frame_empty;

  int n_chk = 0;
  int n_err = 0;

  logic rdy_rand = 1'b0;
  logic rdy_val  = 1'b1;

  logic [8:0] got [0:255];
  int got_n = 0;
  int n_rst = 0, n_ovf = 0, n_emp = 0;
  int stab_bad = 0;
  logic       hold_prev = 1'b0;
  logic [8:0] prev_out = '0;

  uart_frame_decoder #(.MAX_FRAME_LEN(4)) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast), .in_frame(in_frame), .err_restart(err_restart),
    .err_overflow(err_overflow), .frame_empty(frame_empty)
  );

  always #5 aclk = ~aclk;

  initial m_axis_tready = 1'b1;
  always @(posedge aclk) begin
    #1;
    m_axis_tready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
  end

  // Transfers, pulses and stall stability, sampled mid-cycle.
  always @(negedge aclk) begin
    if (areset) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev && (!m_axis_tvalid || {m_axis_tlast, m_axis_tdata} !== prev_out))
        stab_bad++;
      hold_prev = m_axis_tvalid && !m_axis_tready;
      prev_out  = {m_axis_tlast, m_axis_tdata};
      if (m_axis_tvalid && m_axis_tready && got_n < 256) begin
        got[got_n] = {m_axis_tlast, m_axis_tdata};
        got_n++;
      end
      if (err_restart)  n_rst++;
      if (err_overflow) n_ovf++;
      if (frame_empty)  n_emp++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    logic rdy;
    int n = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = b;
    forever begin
      @(negedge aclk);
      rdy = s_axis_tready;
      @(posedge aclk);
      #1;
      if (rdy) break;
      n++;
      if (n > 200) begin
        chk("send_timeout", 32'(n), 32'd0);
        break;
      end
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send(bytes[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [8:0] exp[$], input int base);
    chk({tag, "_count"}, 32'(got_n - base), 32'(exp.size()));
    foreach (exp[i])
      if (base + i < got_n) chk({tag, "_byte"}, 32'(got[base + i]), 32'(exp[i]));
  endtask

  initial begin
    int base, r0, o0, e0;
    logic [8:0] ex[$];

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_tvalid", 32'(m_axis_tvalid), 0);
    chk("rst_tdata",  32'(m_axis_tdata), 0);
    chk("rst_tlast",  32'(m_axis_tlast), 0);
    chk("rst_flags",  32'({in_frame, err_restart, err_overflow, frame_empty}), 0);
    @(posedge aclk); #1;
    areset = 1'b0;
    idle(2);

    // Basic frame, with in_frame tracking.
    base = got_n; r0 = n_rst; o0 = n_ovf; e0 = n_emp;
    send(8'h7D);
    chk("basic_in_frame_open", 32'(in_frame), 1);
    send_seq('{8'h01, 8'h02, 8'h03});
    chk("basic_in_frame_mid", 32'(in_frame), 1);
    send(8'h7E);
    chk("basic_in_frame_close", 32'(in_frame), 0);
    idle(5);
    ex = '{9'h001, 9'h002, 9'h103};
    check_out("basic", ex, base);
    chk("basic_no_err", 32'((n_rst - r0) + (n_ovf - o0) + (n_emp - e0)), 0);

    // Escaping.
    base = got_n;
    send_seq('{8'h7D, 8'h7F, 8'h7E, 8'h7F, 8'h7F, 8'h05, 8'h7E});
    idle(5);
    ex = '{9'h07E, 9'h07F, 9'h105};
    check_out("escape", ex, base);

    // Garbage and empty frame.
    base = got_n; e0 = n_emp;
    send_seq('{8'hAA, 8'h7D, 8'h7E});
    idle(5);
    chk("empty_count", 32'(got_n - base), 0);
    chk("empty_pulse", 32'(n_emp - e0), 1);

    // Restart inside a frame.
    base = got_n; r0 = n_rst;
    send_seq('{8'h7D, 8'h11, 8'h22, 8'h7D, 8'h33, 8'h7E});
    idle(5);
    ex = '{9'h011, 9'h122, 9'h133};
    check_out("restart", ex, base);
    chk("restart_pulse", 32'(n_rst - r0), 1);

    // Overflow with MAX_FRAME_LEN=4.
    base = got_n; o0 = n_ovf;
    send_seq('{8'h7D, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h7E, 8'h7D, 8'h09, 8'h7E});
    idle(5);
    ex = '{9'h001, 9'h002, 9'h003, 9'h104, 9'h109};
    check_out("overflow", ex, base);
    chk("overflow_pulse", 32'(n_ovf - o0), 1);

    // Random downstream stalls on the basic frame.
    base = got_n;
    rdy_rand = 1'b1;
    send_seq('{8'h7D, 8'h01, 8'h02, 8'h03, 8'h7E});
    idle(3);
    rdy_rand = 1'b0;
    rdy_val  = 1'b1;
    idle(8);
    ex = '{9'h001, 9'h002, 9'h103};
    check_out("stall", ex, base);
    chk("stall_stable", 32'(stab_bad), 0);

    // Reset mid-frame with a byte parked in the output register.
    rdy_val = 1'b0;
    idle(2);
    base = got_n;
    send_seq('{8'h7D, 8'h01, 8'h02});
    chk("pre_rst_tvalid", 32'(m_axis_tvalid), 1);
    areset = 1'b1;
    @(posedge aclk); #1;
    chk("midrst_tvalid", 32'(m_axis_tvalid), 0);
    chk("midrst_tdata",  32'(m_axis_tdata), 0);
    chk("midrst_flags",  32'({m_axis_tlast, in_frame, err_restart, err_overflow, frame_empty}), 0);
    areset  = 1'b0;
    rdy_val = 1'b1;
    idle(2);
    send_seq('{8'h7D, 8'h05, 8'h7E});
    idle(5);
    ex = '{9'h105};
    check_out("post_rst", ex, base);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
